rst_sequencer: RTL and testbench

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_sequencer.sv | 175 +++++++++++++++++
 tb/tb_rst_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// Staged reset release sequencer: lock filter, per-stage hold, optional ack handshake.
// Define RST_SEQ_ACK_EN to compile in the stage_ack handshake and ack timeout.
module rst_sequencer #(
   parameter int NUM_STAGES = 4,
   parameter int STAGE_DLY  = 16,
   parameter int LOCK_FILT  = 8,
   parameter int TIMEOUT    = 1024,
   localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                  clk,
   input  logic                  sync_rst,
   input  logic                  locked,
   input  logic                  sw_rst_req,
   input  logic [NUM_STAGES-1:0] stage_ack,
   output logic [NUM_STAGES-1:0] stage_rst,
   output logic                  seq_done,
   output logic [1:0]            fault_code,
   output logic [IW-1:0]         fault_stage
);

   localparam int FMAX = (LOCK_FILT > STAGE_DLY) ? LOCK_FILT : STAGE_DLY;
   localparam int FW = $clog2(FMAX + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] LAST = IW'(NUM_STAGES - 1);

   typedef enum logic [2:0] {
      S_RST,
      S_WAIT_LOCK,
      S_HOLD,
      S_WAIT_ACK,
      S_DONE,
      S_FAULT
   } state_t;

   state_t                  state, state_n;
   logic [IW-1:0]           idx, idx_n;
   logic [FW-1:0]           fcnt, fcnt_n;
   logic [TW-1:0]           tcnt, tcnt_n;
   logic [NUM_STAGES-1:0]   rst_v;
   logic                    done_n;
   logic [1:0]              fc_n;
   logic [IW-1:0]           fs_n;
   logic                    restart;

`ifndef RST_SEQ_ACK_EN
   logic unused_ack;
   assign unused_ack = ^stage_ack;
`endif

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state       <= S_RST;
         idx         <= '0;
         fcnt        <= '0;
         tcnt        <= '0;
         stage_rst   <= '1;
         seq_done    <= 1'b0;
         fault_code  <= 2'b00;
         fault_stage <= '0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         fcnt        <= fcnt_n;
         tcnt        <= tcnt_n;
         stage_rst   <= rst_v;
         seq_done    <= done_n;
         fault_code  <= fc_n;
         fault_stage <= fs_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      fcnt_n  = fcnt;
      tcnt_n  = tcnt;
      rst_v   = stage_rst;
      done_n  = seq_done;
      fc_n    = fault_code;
      fs_n    = fault_stage;
      restart = 1'b0;

      case (state)
         S_RST: begin
            state_n = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            fcnt_n = !locked ? '0 : (fcnt == '1) ? fcnt : fcnt + 1'b1;
            tcnt_n = (tcnt == '1) ? tcnt : tcnt + 1'b1;
            if (locked && (int'(fcnt) + 1 >= LOCK_FILT)) begin
               state_n = S_HOLD;
               idx_n   = '0;
               fcnt_n  = '0;
               tcnt_n  = '0;
            end else if (int'(tcnt) + 1 >= TIMEOUT) begin
               state_n = S_FAULT;
               fc_n    = 2'b01;
               rst_v   = '1;
            end
         end
         S_HOLD: begin
            fcnt_n = (fcnt == '1) ? fcnt : fcnt + 1'b1;
            if (int'(fcnt) + 1 >= STAGE_DLY) begin
               rst_v[idx] = 1'b0;
               fcnt_n     = '0;
               tcnt_n     = '0;
`ifdef RST_SEQ_ACK_EN
               state_n = S_WAIT_ACK;
`else
               // seq_done follows one edge later, from DONE
               if (idx == LAST) begin
                  state_n = S_DONE;
               end else begin
                  idx_n   = idx + 1'b1;
                  state_n = S_HOLD;
               end
`endif
            end
         end
`ifdef RST_SEQ_ACK_EN
         S_WAIT_ACK: begin
            tcnt_n = (tcnt == '1) ? tcnt : tcnt + 1'b1;
            if (stage_ack[idx]) begin
               tcnt_n = '0;
               fcnt_n = '0;
               if (idx == LAST) begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
               end else begin
                  idx_n   = idx + 1'b1;
                  state_n = S_HOLD;
               end
            end else if (int'(tcnt) + 1 >= TIMEOUT) begin
               state_n = S_FAULT;
               fc_n    = 2'b10;
               fs_n    = idx;
               rst_v   = '1;
               done_n  = 1'b0;
            end
         end
`endif
         S_DONE: begin
            done_n = 1'b1;
         end
         S_FAULT: begin
            rst_v  = '1;
            done_n = 1'b0;
         end
         default: begin
            state_n = S_RST;
         end
      endcase

      if ((state == S_HOLD || state == S_WAIT_ACK || state == S_DONE)
          && !locked)
         restart = 1'b1;

      if (sw_rst_req && state != S_RST) begin
         restart = 1'b1;
         fc_n    = 2'b00;
         fs_n    = '0;
      end

      // restart overrides any same-cycle ack, release or timeout
      if (restart) begin
         state_n = S_WAIT_LOCK;
         idx_n   = '0;
         fcnt_n  = '0;
         tcnt_n  = '0;
         rst_v   = '1;
         done_n  = 1'b0;
      end
   end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed table-driven bench for rst_sequencer at default parameters.
// Covers both builds; the RST_SEQ_ACK_EN define selects the ack table.
module tb_rst_sequencer;

   logic       clk = 1'b0;
   logic       sync_rst = 1'b1;
   logic       locked = 1'b0;
   logic       sw_rst_req = 1'b0;
   logic [3:0] stage_ack = 4'h0;
   logic [3:0] stage_rst;
   logic       seq_done;
   logic [1:0] fault_code;
   logic [1:0] fault_stage;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rst_sequencer dut (
      .clk         (clk),
      .sync_rst    (sync_rst),
      .locked      (locked),
      .sw_rst_req  (sw_rst_req),
      .stage_ack   (stage_ack),
      .stage_rst   (stage_rst),
      .seq_done    (seq_done),
      .fault_code  (fault_code),
      .fault_stage (fault_stage)
   );

   typedef struct {
      int         n;
      logic       rst;
      logic       lk;
      logic       sw;
      logic [3:0] ack;
      logic [3:0] e_rst;
      logic       e_done;
      logic [1:0] e_fc;
      logic [1:0] e_fs;
   } vec_t;

   vec_t vq[$];

   task automatic add(input int n, input logic r, input logic lk,
                      input logic sw, input logic [3:0] a,
                      input logic [3:0] er, input logic ed,
                      input logic [1:0] efc, input logic [1:0] efs);
      vec_t v;
      v.n = n; v.rst = r; v.lk = lk; v.sw = sw; v.ack = a;
      v.e_rst = er; v.e_done = ed; v.e_fc = efc; v.e_fs = efs;
      vq.push_back(v);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] er,
                      input logic ed, input logic [1:0] efc,
                      input logic [1:0] efs);
      logic [8:0] act, exp;
      act = {stage_rst, seq_done, fault_code, fault_stage};
      exp = {er, ed, efc, efs};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: rst/done/fc/fs got %b/%b/%b/%b want %b/%b/%b/%b",
                  name, stage_rst, seq_done, fault_code, fault_stage,
                  er, ed, efc, efs);
      end
   endtask

   initial begin
      // n, rst, lk, sw, ack, exp stage_rst, done, fc, fs
`ifdef RST_SEQ_ACK_EN
      add(3,    1, 1, 0, 4'h0, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h0, 4'hF, 0, 2'd0, 2'd0);
      add(23,   0, 1, 0, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h0, 4'hE, 0, 2'd0, 2'd0);
      add(2,    0, 1, 0, 4'hE, 4'hE, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h1, 4'hE, 0, 2'd0, 2'd0);
      add(15,   0, 1, 0, 4'hF, 4'hE, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h0, 4'hC, 0, 2'd0, 2'd0);
      add(2,    0, 1, 0, 4'hD, 4'hC, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h2, 4'hC, 0, 2'd0, 2'd0);
      add(15,   0, 1, 0, 4'hF, 4'hC, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h0, 4'h8, 0, 2'd0, 2'd0);
      add(2,    0, 1, 0, 4'hB, 4'h8, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h4, 4'h8, 0, 2'd0, 2'd0);
      add(15,   0, 1, 0, 4'hF, 4'h8, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h0, 4'h0, 0, 2'd0, 2'd0);
      add(2,    0, 1, 0, 4'h7, 4'h0, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h8, 4'h0, 1, 2'd0, 2'd0);
      add(5,    0, 1, 0, 4'hF, 4'h0, 1, 2'd0, 2'd0);
      add(1,    0, 0, 0, 4'h0, 4'hF, 0, 2'd0, 2'd0);
      add(23,   0, 1, 0, 4'h0, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h0, 4'hE, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h1, 4'hE, 0, 2'd0, 2'd0);
      add(15,   0, 1, 0, 4'h0, 4'hE, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h0, 4'hC, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h2, 4'hC, 0, 2'd0, 2'd0);
      add(15,   0, 1, 0, 4'h0, 4'hC, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h0, 4'h8, 0, 2'd0, 2'd0);
      add(1023, 0, 1, 0, 4'hB, 4'h8, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'hB, 4'hF, 0, 2'd2, 2'd2);
      add(5,    0, 0, 0, 4'hF, 4'hF, 0, 2'd2, 2'd2);
      add(1,    0, 1, 1, 4'h0, 4'hF, 0, 2'd0, 2'd0);
      add(23,   0, 1, 0, 4'h0, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h0, 4'hE, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h1, 4'hE, 0, 2'd0, 2'd0);
      add(15,   0, 1, 0, 4'h0, 4'hE, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h0, 4'hC, 0, 2'd0, 2'd0);
      add(1,    1, 1, 0, 4'h2, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h0, 4'hF, 0, 2'd0, 2'd0);
      add(23,   0, 1, 0, 4'h0, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h0, 4'hE, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h1, 4'hE, 0, 2'd0, 2'd0);
      add(15,   0, 1, 0, 4'h0, 4'hE, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h0, 4'hC, 0, 2'd0, 2'd0);
      add(1,    0, 1, 1, 4'h2, 4'hF, 0, 2'd0, 2'd0);
      add(23,   0, 1, 0, 4'h0, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'h0, 4'hE, 0, 2'd0, 2'd0);
`else
      add(3,    1, 1, 0, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(23,   0, 1, 0, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'hF, 4'hE, 0, 2'd0, 2'd0);
      add(15,   0, 1, 0, 4'hF, 4'hE, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'hF, 4'hC, 0, 2'd0, 2'd0);
      add(16,   0, 1, 0, 4'hF, 4'h8, 0, 2'd0, 2'd0);
      add(15,   0, 1, 0, 4'hF, 4'h8, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'hF, 4'h0, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'hF, 4'h0, 1, 2'd0, 2'd0);
      add(7,    0, 1, 0, 4'hF, 4'h0, 1, 2'd0, 2'd0);
      add(1,    0, 0, 0, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(5,    0, 1, 0, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 0, 0, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(23,   0, 1, 0, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'hF, 4'hE, 0, 2'd0, 2'd0);
      add(3,    0, 1, 0, 4'hF, 4'hE, 0, 2'd0, 2'd0);
      add(1,    0, 1, 1, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(23,   0, 1, 0, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'hF, 4'hE, 0, 2'd0, 2'd0);
      add(16,   0, 1, 0, 4'hF, 4'hC, 0, 2'd0, 2'd0);
      add(1,    1, 1, 0, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(23,   0, 1, 0, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'hF, 4'hE, 0, 2'd0, 2'd0);
      add(1,    0, 0, 0, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(23,   0, 1, 0, 4'hF, 4'hF, 0, 2'd0, 2'd0);
      add(1,    0, 1, 0, 4'hF, 4'hE, 0, 2'd0, 2'd0);
`endif

      for (int i = 0; i < vq.size(); i++) begin
         sync_rst   = vq[i].rst;
         locked     = vq[i].lk;
         sw_rst_req = vq[i].sw;
         stage_ack  = vq[i].ack;
         step(vq[i].n);
         chk($sformatf("row%0d", i), vq[i].e_rst, vq[i].e_done,
             vq[i].e_fc, vq[i].e_fs);
      end

      // lock timeout, FAULT ignores locked, sync_rst exits FAULT
      sw_rst_req = 1'b0;
      stage_ack  = 4'h0;
      sync_rst   = 1'b1;
      step(1);
      sync_rst = 1'b0;
      locked   = 1'b0;
      step(1);
      step(1023);
      chk("lock_to_pre", 4'hF, 1'b0, 2'd0, 2'd0);
      step(1);
      chk("lock_to", 4'hF, 1'b0, 2'd1, 2'd0);
      locked = 1'b1;
      step(10);
      chk("fault_hold", 4'hF, 1'b0, 2'd1, 2'd0);
      sync_rst = 1'b1;
      step(1);
      chk("fault_sync", 4'hF, 1'b0, 2'd0, 2'd0);
      sync_rst = 1'b0;
      step(1);
      step(23);
      chk("relock_pre", 4'hF, 1'b0, 2'd0, 2'd0);
      step(1);
      chk("relock", 4'hE, 1'b0, 2'd0, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
